fpu_div_iterative: RTL and testbench

Multi-cycle FP16 (IEEE 754 binary16) divider for the tinyqv FPU peripheral. It computes `a[15:0] / b[15:0]` with a restoring mantissa divider that retires one quotient bit per cycle. It uses the same `valid_in`/`valid_out` single-operation handshake and 32-bit operand/result framing as the FPU multiplier, so the FPU register front end drives both units identically.

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fpu_fp16_classify.sv | 31 +++
 rtl/fpu_div_iterative.sv | 161 ++++++++++++++++
 tb/tb_fpu_div_iterative.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP16 constants and FSM state encoding for the FPU units
package fpu_pkg;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;
    localparam int FP16_SIG_W  = FP16_FRAC_W + 1;
    localparam int FP16_BIAS   = 15;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'd31;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_DIVIDE    = 3'd2;
    localparam logic [2:0] ST_NORMALIZE = 3'd3;
    localparam logic [2:0] ST_PACK      = 3'd4;

endpackage

// File: rtl/fpu_fp16_classify.sv
// rtl/fpu_fp16_classify.sv - combinational FP16 field split and operand classification
//   value   : FP16 operand
//   sign    : sign bit
//   exp     : biased exponent
//   sig     : significand {1, frac}; hidden bit always set (subnormals flush to zero)
//   is_zero : exponent field is zero, any fraction
//   is_inf  : exponent all ones, fraction zero
//   is_nan  : exponent all ones, fraction nonzero
module fpu_fp16_classify
    import fpu_pkg::*;
(
    input  logic [15:0] value,
    output logic        sign,
    output logic [4:0]  exp,
    output logic [10:0] sig,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    logic [9:0] frac;

    assign sign    = value[15];
    assign exp     = value[14:10];
    assign frac    = value[9:0];
    assign sig     = {1'b1, frac};
    assign is_zero = (exp == 5'd0);
    assign is_inf  = (exp == FP16_EXP_MAX) && (frac == 10'd0);
    assign is_nan  = (exp == FP16_EXP_MAX) && (frac != 10'd0);

endmodule

// File: rtl/fpu_div_iterative.sv
// rtl/fpu_div_iterative.sv - multi-cycle FP16 divider, restoring mantissa division, 1 bit/cycle
//   clk, rst_n : clock, asynchronous active-low reset
//   valid_in   : start request, sampled only when idle
//   a, b       : operands, FP16 in [15:0]; upper halves ignored
//   valid_out  : one-cycle completion pulse
//   result     : {16'b0, quotient}, held until the next completion
//   busy       : high while an operation is in flight
module fpu_div_iterative (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] result,
    output logic        busy
);

    import fpu_pkg::*;

    logic [2:0]        state;
    logic [3:0]        cnt;
    logic [15:0]       a_reg;
    logic [15:0]       b_reg;
    logic [11:0]       rem;
    logic [11:0]       q;
    logic [10:0]       mb_reg;
    logic              sign_q;
    logic signed [6:0] exp_q;
    logic signed [6:0] nexp_q;
    logic [9:0]        mant_q;

    logic        sign_a, sign_b;
    logic [4:0]  exp_a, exp_b;
    logic [10:0] sig_a, sig_b;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    logic [11:0] rem_diff;
    logic        rem_ge;
    logic [15:0] pack_val;

    logic unused_hi;
    assign unused_hi = ^{a[31:16], b[31:16]};

    // Operand registers stay stable for the whole operation, so the
    // classification outputs can be consumed combinationally in any state.
    fpu_fp16_classify u_class_a (
        .value   (a_reg),
        .sign    (sign_a),
        .exp     (exp_a),
        .sig     (sig_a),
        .is_zero (zero_a),
        .is_inf  (inf_a),
        .is_nan  (nan_a)
    );

    fpu_fp16_classify u_class_b (
        .value   (b_reg),
        .sign    (sign_b),
        .exp     (exp_b),
        .sig     (sig_b),
        .is_zero (zero_b),
        .is_inf  (inf_b),
        .is_nan  (nan_b)
    );

    assign busy     = (state != ST_IDLE);
    assign rem_diff = rem - {1'b0, mb_reg};
    assign rem_ge   = (rem >= {1'b0, mb_reg});

    always_comb begin
        pack_val = {sign_q, nexp_q[4:0], mant_q};
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            pack_val = FP16_QNAN;
        end else if (inf_a || zero_b) begin
            pack_val = {sign_q, FP16_EXP_MAX, 10'd0};
        end else if (zero_a || inf_b) begin
            pack_val = {sign_q, 15'd0};
        end else if (nexp_q >= 7'sd31) begin
            pack_val = {sign_q, FP16_EXP_MAX, 10'd0};
        end else if (nexp_q <= 7'sd0) begin
            pack_val = {sign_q, 15'd0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            valid_out <= 1'b0;
            result    <= 32'd0;
            a_reg     <= 16'd0;
            b_reg     <= 16'd0;
            rem       <= 12'd0;
            q         <= 12'd0;
            mb_reg    <= 11'd0;
            sign_q    <= 1'b0;
            exp_q     <= 7'sd0;
            nexp_q    <= 7'sd0;
            mant_q    <= 10'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_out <= 1'b0;
                    if (valid_in) begin
                        a_reg <= a[15:0];
                        b_reg <= b[15:0];
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    rem    <= {1'b0, sig_a};
                    mb_reg <= sig_b;
                    q      <= 12'd0;
                    cnt    <= 4'd0;
                    sign_q <= sign_a ^ sign_b;
                    // 7-bit signed range covers -16..46 without wrap.
                    exp_q  <= {2'b00, exp_a} - {2'b00, exp_b} + 7'd15;
                    state  <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    // Remainder stays below 2*mb, so bit 11 of the
                    // difference is always clear and the shift is lossless.
                    if (rem_ge) begin
                        q   <= {q[10:0], 1'b1};
                        rem <= {rem_diff[10:0], 1'b0};
                    end else begin
                        q   <= {q[10:0], 1'b0};
                        rem <= {rem[10:0], 1'b0};
                    end
                    if (cnt == 4'd11) begin
                        cnt   <= 4'd0;
                        state <= ST_NORMALIZE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_NORMALIZE: begin
                    // Quotient lies in [0.5, 2): at most one position of shift.
                    if (q[11]) begin
                        mant_q <= q[10:1];
                        nexp_q <= exp_q;
                    end else begin
                        mant_q <= q[9:0];
                        nexp_q <= exp_q - 7'sd1;
                    end
                    state <= ST_PACK;
                end
                ST_PACK: begin
                    valid_out <= 1'b1;
                    result    <= {16'd0, pack_val};
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_iterative.sv
// tb/tb_fpu_div_iterative.sv - directed self-checking bench for fpu_div_iterative
module tb_fpu_div_iterative;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_out;
    logic [31:0] result;
    logic        busy;

    int checks;
    int failures;

    fpu_div_iterative dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .a         (a),
        .b         (b),
        .valid_out (valid_out),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp_v);
        end
    endtask

    // Single operation: pulse valid_in for one edge, wait for completion,
    // check latency, busy behaviour, pulse width and result.
    task automatic do_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                         input logic [31:0] exp_v);
        int n;
        @(negedge clk);
        a = oa;
        b = ob;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check_eq({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (!valid_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, n, 32'd16);
        check_eq({tag, "_result"}, result, exp_v);
        check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_pulse_1cyc"}, {31'd0, valid_out}, 32'd0);
        check_eq({tag, "_result_hold"}, result, exp_v);
    endtask

    initial begin
        int pulses;
        int pulse_at [3];
        logic [31:0] last_res;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal values
        do_op("three_div_one", 32'h0000_4200, 32'h0000_3C00, 32'h0000_4200);
        do_op("one_div_three", 32'h0000_3C00, 32'h0000_4200, 32'h0000_3555);
        do_op("four_div_mtwo", 32'h0000_4400, 32'h0000_C000, 32'h0000_C000);
        // Specials
        do_op("x_div_zero",    32'h0000_3C00, 32'h0000_0000, 32'h0000_7C00);
        do_op("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h0000_7E00);
        do_op("minf_div_x",    32'h0000_FC00, 32'h0000_3C00, 32'h0000_FC00);
        do_op("x_div_inf",     32'h0000_3C00, 32'h0000_7C00, 32'h0000_0000);
        do_op("nan_div_x",     32'h0000_7E01, 32'h0000_3C00, 32'h0000_7E00);
        do_op("inf_div_inf",   32'h0000_7C00, 32'h0000_FC00, 32'h0000_7E00);
        // Range
        do_op("overflow",      32'h0000_7BFF, 32'h0000_1400, 32'h0000_7C00);
        do_op("underflow",     32'h0000_0400, 32'h0000_7800, 32'h0000_0000);
        do_op("subnormal_a",   32'h0000_0001, 32'h0000_3C00, 32'h0000_0000);
        do_op("upper_garbage", 32'hFFFF_4200, 32'hABCD_3C00, 32'h0000_4200);

        // Request while busy is dropped
        @(negedge clk);
        a = 32'h0000_4200;
        b = 32'h0000_3C00;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'h0000_3C00;
        b = 32'h0000_4200;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        pulses   = 0;
        last_res = 32'd0;
        for (int i = 0; i < 40; i++) begin
            if (valid_out) begin
                pulses++;
                last_res = result;
            end
            @(negedge clk);
        end
        check_eq("drop_pulse_count", pulses, 32'd1);
        check_eq("drop_result", last_res, 32'h0000_4200);

        // valid_in held high: one completion every 16 cycles
        a = 32'h0000_4400;
        b = 32'h0000_C000;
        valid_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) pulse_at[i] = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (valid_out) begin
                if (pulses < 3) pulse_at[pulses] = i;
                pulses++;
            end
        end
        valid_in = 1'b0;
        check_eq("held_pulse_count", pulses, 32'd3);
        check_eq("held_first", pulse_at[0], 32'd16);
        check_eq("held_second", pulse_at[1], 32'd32);
        check_eq("held_third", pulse_at[2], 32'd48);
        check_eq("held_result", result, 32'h0000_C000);
        repeat (20) @(negedge clk);

        // Reset in the middle of DIVIDE aborts with no completion
        @(negedge clk);
        a = 32'h0000_3C00;
        b = 32'h0000_4200;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_result", result, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_valid_out", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        check_eq("abort_no_pulse", pulses, 32'd0);
        do_op("after_reset", 32'h0000_4200, 32'h0000_3C00, 32'h0000_4200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
